// File: rtl/branch_history_ctrl.sv
// Branch history table of 2-bit saturating counters with a post-reset/flush clear sequencer.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
`ifndef WORD
`define WORD [31:0]
`endif

module branch_history_ctrl #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic `WORD lookup_pc,
  output logic       predict,
  input  logic       upd_valid,
  input  logic `WORD upd_pc,
  input  logic       upd_taken,
  input  logic       flush_req,
  output logic       bht_ready
);

  localparam int   DEPTH    = 1 << IDX_W;
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  logic             state;
  logic [IDX_W-1:0] clr_ptr;
  logic [1:0]       cnt [DEPTH];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_we;
  logic [1:0]       cur_cnt;
  logic [1:0]       nxt_cnt;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                            upd_pc[31:IDX_W+2], upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  assign lookup_idx = lookup_pc[IDX_W+1:2] ^ ghr;
  assign upd_idx    = upd_pc[IDX_W+1:2] ^ ghr;

  // History is zeroed whenever a clear starts or restarts.
  always_ff @(posedge clk) begin
    if (rst || flush_req)
      ghr <= '0;
    else if (upd_we)
      ghr <= {ghr[IDX_W-2:0], upd_taken};
  end
`else
  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign upd_idx    = upd_pc[IDX_W+1:2];
`endif

  assign bht_ready = (state == ST_RUN);
  assign predict   = bht_ready & cnt[lookup_idx][1];

  // A flush cycle never trains, so the dropped update cannot race the clear.
  assign upd_we  = upd_valid & bht_ready & ~flush_req;
  assign cur_cnt = cnt[upd_idx];

  always_comb begin
    nxt_cnt = cur_cnt;
    if (upd_taken) begin
      if (cur_cnt != 2'b11) nxt_cnt = cur_cnt + 2'b01;
    end else begin
      if (cur_cnt != 2'b00) nxt_cnt = cur_cnt - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (flush_req) begin
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == '1) state <= ST_RUN;
          end
        end
        default: begin
          if (flush_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end
        end
      endcase
    end
  end

  // Single write port: clear owns it while not ready, training otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR)
        cnt[clr_ptr] <= INIT_CNT;
      else if (upd_we)
        cnt[upd_idx] <= nxt_cnt;
    end
  end

endmodule
